// File: rtl/pyrm_imem_arbiter.sv
// Two-requester instruction-memory arbiter with alternating priority, bounded outstanding
// requests, and in-order response routing through a small tag FIFO.
module pyrm_imem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              reset_pyri,
  input  logic [ADDR_W-1:0] req0_addr_pyri,
  input  logic              req0_valid_pyri,
  output logic              req0_retry_pyro,
  input  logic [ADDR_W-1:0] req1_addr_pyri,
  input  logic              req1_valid_pyri,
  output logic              req1_retry_pyro,
  output logic [ADDR_W-1:0] mem_addr_pyro,
  output logic              mem_valid_pyro,
  input  logic              mem_retry_pyri,
  input  logic [DATA_W-1:0] mem_rsp_data_pyri,
  input  logic              mem_rsp_valid_pyri,
  output logic              mem_rsp_retry_pyro,
  output logic [DATA_W-1:0] rsp0_data_pyro,
  output logic [DATA_W-1:0] rsp1_data_pyro,
  output logic              rsp0_valid_pyro,
  output logic              rsp1_valid_pyro,
  input  logic              rsp0_retry_pyri,
  input  logic              rsp1_retry_pyri,
  output logic              err_pyro
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_tag [MAX_OUT];
  logic             r_prio;
  logic             r_err;

  logic w_full;
  logic w_gnt;
  logic w_gnt_idx;
  logic w_push;
  logic w_busy;
  logic w_head;
  logic w_pop;
  logic w_drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) ptr_inc = '0;
    else               ptr_inc = p + 1'b1;
  endfunction

  // Request side: full is judged on registered count only, so a pop never unblocks a grant early.
  always_comb begin
    w_full    = (r_count == FULL_CNT);
    w_gnt     = !w_full && (req0_valid_pyri || req1_valid_pyri);
    w_gnt_idx = (req0_valid_pyri && req1_valid_pyri) ? r_prio : req1_valid_pyri;
    w_push    = w_gnt && !mem_retry_pyri;
  end

  assign mem_valid_pyro  = w_gnt;
  assign mem_addr_pyro   = !w_gnt     ? '0 :
                           w_gnt_idx  ? req1_addr_pyri : req0_addr_pyri;
  assign req0_retry_pyro = !(w_gnt && !w_gnt_idx && !mem_retry_pyri);
  assign req1_retry_pyro = !(w_gnt &&  w_gnt_idx && !mem_retry_pyri);

  // Response side: the FIFO head tag steers the response; with nothing outstanding it is dropped.
  always_comb begin
    w_busy = (r_count != '0);
    w_head = r_tag[r_rptr];
    w_pop  = w_busy && mem_rsp_valid_pyri && !mem_rsp_retry_pyro;
    w_drop = !w_busy && mem_rsp_valid_pyri;
  end

  assign rsp0_data_pyro     = mem_rsp_data_pyri;
  assign rsp1_data_pyro     = mem_rsp_data_pyri;
  assign rsp0_valid_pyro    = w_busy && !w_head && mem_rsp_valid_pyri;
  assign rsp1_valid_pyro    = w_busy &&  w_head && mem_rsp_valid_pyri;
  assign mem_rsp_retry_pyro = w_busy && (w_head ? rsp1_retry_pyri : rsp0_retry_pyri);
  assign err_pyro           = r_err;

  always_ff @(posedge clk or negedge reset_pyri) begin
    if (!reset_pyri) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_prio  <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) r_tag[i] <= 1'b0;
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= w_gnt_idx;
        r_wptr        <= ptr_inc(r_wptr);
        r_prio        <= !w_gnt_idx;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pyrm_imem_arbiter.sv
// Table-driven bench for pyrm_imem_arbiter with a tag scoreboard for response routing.
module tb_pyrm_imem_arbiter;

  localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_1000;

  // inputs: v0 v1 mr rv r0r r1r | expected: mv gi ret0 ret1 r0v r1v mrr err
  typedef struct packed {
    logic v0, v1, mr, rv, r0r, r1r;
    logic mv, gi, ret0, ret1, r0v, r1v, mrr, err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_pyri;
  logic [63:0] req0_addr, req1_addr, mem_addr;
  logic        req0_valid, req1_valid, req0_retry, req1_retry;
  logic        mem_valid, mem_retry;
  logic [31:0] rsp_data_in, rsp0_data, rsp1_data;
  logic        rsp_valid_in, mem_rsp_retry;
  logic        rsp0_valid, rsp1_valid, rsp0_retry, rsp1_retry, err;

  int checks = 0;
  int failures = 0;
  bit sb[$];
  vec_t tbl [24];
  vec_t post [3];

  always #5 clk = ~clk;

  pyrm_imem_arbiter #(.ADDR_W(64), .DATA_W(32), .MAX_OUT(2)) dut (
    .clk               (clk),
    .reset_pyri        (reset_pyri),
    .req0_addr_pyri    (req0_addr),
    .req0_valid_pyri   (req0_valid),
    .req0_retry_pyro   (req0_retry),
    .req1_addr_pyri    (req1_addr),
    .req1_valid_pyri   (req1_valid),
    .req1_retry_pyro   (req1_retry),
    .mem_addr_pyro     (mem_addr),
    .mem_valid_pyro    (mem_valid),
    .mem_retry_pyri    (mem_retry),
    .mem_rsp_data_pyri (rsp_data_in),
    .mem_rsp_valid_pyri(rsp_valid_in),
    .mem_rsp_retry_pyro(mem_rsp_retry),
    .rsp0_data_pyro    (rsp0_data),
    .rsp1_data_pyro    (rsp1_data),
    .rsp0_valid_pyro   (rsp0_valid),
    .rsp1_valid_pyro   (rsp1_valid),
    .rsp0_retry_pyri   (rsp0_retry),
    .rsp1_retry_pyri   (rsp1_retry),
    .err_pyro          (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] d;
    logic [63:0] exp_addr;
    bit          t;
    @(negedge clk);
    req0_valid   = v.v0;
    req1_valid   = v.v1;
    mem_retry    = v.mr;
    rsp_valid_in = v.rv;
    rsp0_retry   = v.r0r;
    rsp1_retry   = v.r1r;
    d            = $urandom;
    rsp_data_in  = d;
    #1;
    exp_addr = v.mv ? (v.gi ? A1 : A0) : 64'd0;
    check({tag, "_mem_valid"}, {63'd0, mem_valid}, {63'd0, v.mv});
    check({tag, "_mem_addr"}, mem_addr, exp_addr);
    check({tag, "_req0_retry"}, {63'd0, req0_retry}, {63'd0, v.ret0});
    check({tag, "_req1_retry"}, {63'd0, req1_retry}, {63'd0, v.ret1});
    check({tag, "_rsp0_valid"}, {63'd0, rsp0_valid}, {63'd0, v.r0v});
    check({tag, "_rsp1_valid"}, {63'd0, rsp1_valid}, {63'd0, v.r1v});
    check({tag, "_mem_rsp_retry"}, {63'd0, mem_rsp_retry}, {63'd0, v.mrr});
    check({tag, "_err"}, {63'd0, err}, {63'd0, v.err});
    check({tag, "_rsp_data"}, {rsp1_data, rsp0_data}, {d, d});
    if ((v.r0v || v.r1v) && !v.mrr) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_underflow"}, 64'd1, 64'd0);
      end else begin
        t = sb.pop_front();
        check({tag, "_sb_route"}, {62'd0, rsp1_valid, rsp0_valid}, t ? 64'd2 : 64'd1);
      end
    end
    if (v.mv && !v.mr) sb.push_back(v.gi);
  endtask

  initial begin
    tbl[0]  = 14'b110000_10010000;  // alternating grants with 1-cycle responses
    tbl[1]  = 14'b110100_11101000;
    tbl[2]  = 14'b110100_10010100;
    tbl[3]  = 14'b110100_11101000;
    tbl[4]  = 14'b000100_00110100;
    tbl[5]  = 14'b110000_10010000;  // fill to MAX_OUT, no pop bypass
    tbl[6]  = 14'b110000_11100000;
    tbl[7]  = 14'b110000_00110000;
    tbl[8]  = 14'b110100_00111000;
    tbl[9]  = 14'b110000_10010000;
    tbl[10] = 14'b000101_00110110;  // head tag 1 stalled by rsp1_retry
    tbl[11] = 14'b000101_00110110;
    tbl[12] = 14'b000100_00110100;
    tbl[13] = 14'b000101_00111000;
    tbl[14] = 14'b111000_11110000;  // memory stall holds grant and prio
    tbl[15] = 14'b111000_11110000;
    tbl[16] = 14'b111000_11110000;
    tbl[17] = 14'b110000_11100000;
    tbl[18] = 14'b000100_00110100;
    tbl[19] = 14'b000100_00110000;  // orphan response sets sticky err
    tbl[20] = 14'b000000_00110001;
    tbl[21] = 14'b100000_10010001;
    tbl[22] = 14'b100000_10010001;
    tbl[23] = 14'b110000_00110001;
    post[0] = 14'b110000_10010000;
    post[1] = 14'b110000_11100000;
    post[2] = 14'b110000_00110000;

    req0_addr = A0;
    req1_addr = A1;
    reset_pyri = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; mem_retry = 1'b0;
    rsp_valid_in = 1'b0; rsp0_retry = 1'b0; rsp1_retry = 1'b0;
    rsp_data_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("reset_rsp_valids", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    reset_pyri = 1'b1;

    for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Async reset mid-cycle with two outstanding and err set.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; mem_retry = 1'b0;
    rsp_valid_in = 1'b1; rsp0_retry = 1'b0; rsp1_retry = 1'b0;
    #2 reset_pyri = 1'b0;
    #1;
    check("rst_err_clear", {63'd0, err}, 64'd0);
    check("rst_rsp_valids", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    check("rst_mem_rsp_retry", {63'd0, mem_rsp_retry}, 64'd0);
    check("rst_count_zero_grant", {63'd0, mem_valid}, 64'd1);
    check("rst_prio_zero_addr", mem_addr, A0);
    sb.delete();
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_valid_in = 1'b0;
    #1;
    check("rst_idle_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_hold_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    reset_pyri = 1'b1;
    for (int i = 0; i < 3; i++) apply(post[i], $sformatf("p%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running expected=done");
    $fatal(1);
  end

endmodule

// File: doc/pyrm_imem_arbiter.md
PYRM_IMEM_ARBITER -- requirements
Module: pyrm_imem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 64, request address width; DATA_W, 32, response data width; MAX_OUT, 2, maximum outstanding memory requests (2..4).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be:
  clk  in  1  clock, all state updates on rising edge
  reset_pyri  in  1  asynchronous active-low reset
  req0_addr_pyri  in  ADDR_W  requester 0 (fetch) address
  req0_valid_pyri  in  1  requester 0 request valid
  req0_retry_pyro  out  1  requester 0 must hold request
  req1_addr_pyri  in  ADDR_W  requester 1 (load/debug) address
  req1_valid_pyri  in  1  requester 1 request valid
  req1_retry_pyro  out  1  requester 1 must hold request
  mem_addr_pyro  out  ADDR_W  shared memory port address
  mem_valid_pyro  out  1  shared memory request valid
  mem_retry_pyri  in  1  memory stalls request
  mem_rsp_data_pyri  in  DATA_W  memory response data
  mem_rsp_valid_pyri  in  1  memory response valid
  mem_rsp_retry_pyro  out  1  memory must hold response
  rsp0_data_pyro / rsp1_data_pyro  out  DATA_W  response data to requester 0 / 1
  rsp0_valid_pyro / rsp1_valid_pyro  out  1  response valid to requester 0 / 1
  rsp0_retry_pyri / rsp1_retry_pyri  in  1  requester 0 / 1 stalls response
  err_pyro  out  1  sticky: response received with no request outstanding

Function
REQ-004 A transfer on any valid/retry pair SHALL occur exactly in a cycle where valid is high and retry is low.
REQ-005 full SHALL be (count == MAX_OUT), where count is the outstanding-request counter.
REQ-006 When not full, grant SHALL go to the single valid requester; if both are valid, grant SHALL go to requester prio.
REQ-007 When full or neither requester is valid, there SHALL be no grant, and mem_valid_pyro SHALL be 0.
REQ-008 mem_valid_pyro SHALL be 1 iff a grant exists; mem_addr_pyro SHALL be the granted address, else 0.
REQ-009 reqN_retry_pyro SHALL be 0 only when N is granted and mem_retry_pyri is 0; otherwise 1 (including when reqN_valid_pyri is 0).
REQ-010 On each accepted memory request, prio SHALL become the non-granted index; otherwise prio SHALL hold. A stalled grant SHALL NOT move prio.
REQ-011 An accepted memory request SHALL push the granted index into an in-order tag FIFO of depth MAX_OUT and increment count.
REQ-012 A response is routed only when count > 0; the FIFO head tag H then selects the destination.
REQ-013 When routed: rspH_valid_pyro = mem_rsp_valid_pyri, rsp(not H)_valid_pyro = 0, and mem_rsp_retry_pyro = rspH_retry_pyri.
REQ-014 Both rsp data outputs SHALL always equal mem_rsp_data_pyri (combinational pass-through, zero added latency).
REQ-015 An accepted response SHALL pop the FIFO head and decrement count.
REQ-016 A push and a pop in the same cycle SHALL leave count unchanged and keep FIFO order correct.
REQ-017 The full check SHALL use registered count; there is no pop-bypass, so a same-cycle pop does not unblock a grant.
REQ-018 If mem_rsp_valid_pyri is 1 while count == 0: mem_rsp_retry_pyro = 0, the response is dropped, both rsp valids = 0, and err_pyro sets and stays set until reset.
REQ-019 FIFO pointers SHALL wrap modulo MAX_OUT; count SHALL never exceed MAX_OUT or go below 0.
REQ-020 Request and response paths SHALL operate independently in the same cycle.

Reset
REQ-021 While reset_pyri = 0, asynchronously: count = 0, FIFO pointers = 0, prio = 0, err_pyro = 0.
REQ-022 Any request or response in flight at reset assertion SHALL be discarded. After reset, mem_valid_pyro, rsp0_valid_pyro and rsp1_valid_pyro SHALL be 0 until new inputs arrive.
REQ-023 State SHALL update from the first rising clk edge after reset_pyri returns to 1.

Verification
REQ-024 The bench SHALL cover:
  1. Both valid continuously, addr0 = 0x80000000, addr1 = 0x1000, mem_retry = 0, responses 1 cycle later -> mem_addr alternates 0x80000000, 0x1000, ... starting with req0; rsp0/rsp1 receive data in the same order.
  2. MAX_OUT = 2 requests accepted, no responses -> mem_valid = 0 and both req retries = 1. One response accepted -> a grant is allowed the following cycle.
  3. mem_retry = 1 for 3 cycles with both valid -> mem_addr stable at the prio requester; prio unchanged until acceptance.
  4. Head tag = 1 with rsp1_retry = 1 -> rsp1_valid = 1 held, mem_rsp_retry = 1, rsp0_valid = 0, no pop. Then rsp1_retry = 0 -> pop.
  5. mem_rsp_valid = 1 with count = 0 -> err_pyro = 1 on the next cycle and sticky; no rsp valid asserted.
  6. reset_pyri = 0 asserted mid-cycle with 2 outstanding -> count = 0 and err_pyro = 0 immediately; first grant after release goes to req0.
